// File: rtl/pre_decode_ras.sv
// Fetch pre-decoder: finds the first JAL/JALR in a bundle, classifies it and predicts its
// target. A speculative circular return-address stack supplies the targets of returns.
module pre_decode_ras #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RAS_DEPTH   = 8,
    localparam int unsigned SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     bundle_vld_i,
    output logic                     bundle_rdy_o,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [32*FETCH_WIDTH-1:0] instr_data_i,
    input  logic [FETCH_WIDTH-1:0]   instr_vld_i,
    input  logic                     flush_i,
    input  logic                     ras_clear_i,
    output logic                     pd_vld_o,
    input  logic                     pd_rdy_i,
    output logic [XLEN-1:0]          pd_pc_o,
    output logic [32*FETCH_WIDTH-1:0] pd_instr_o,
    output logic [FETCH_WIDTH-1:0]   pd_slot_vld_o,
    output logic                     pd_jump_o,
    output logic [SLOT_W-1:0]        pd_jump_slot_o,
    output logic                     pd_call_o,
    output logic                     pd_return_o,
    output logic                     redirect_o,
    output logic [XLEN-1:0]          redirect_pc_o,
    output logic                     ras_empty_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    logic                      r_vld;
    logic [XLEN-1:0]           r_pc;
    logic [32*FETCH_WIDTH-1:0] r_instr;
    logic [FETCH_WIDTH-1:0]    r_slot_vld;
    logic                      r_jump;
    logic [SLOT_W-1:0]         r_jump_slot;
    logic                      r_call;
    logic                      r_return;
    logic                      r_redirect;
    logic [XLEN-1:0]           r_redirect_pc;

    logic [XLEN-1:0]           r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]          r_ptr;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_found;
    logic [SLOT_W-1:0]         w_slot;
    logic [31:0]               w_instr;
    logic [FETCH_WIDTH-1:0]    w_mask;

    // Priority scan for the first valid jump; later slots are masked off.
    always_comb begin
        w_found = 1'b0;
        w_slot  = '0;
        w_instr = '0;
        w_mask  = instr_vld_i;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (w_found) begin
                w_mask[k] = 1'b0;
            end else if (instr_vld_i[k] && ((instr_data_i[32*k +: 7] == OP_JAL) ||
                                            (instr_data_i[32*k +: 7] == OP_JALR))) begin
                w_found = 1'b1;
                w_slot  = SLOT_W'(k);
                w_instr = instr_data_i[32*k +: 32];
            end
        end
    end

    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic             w_is_jal;
    logic             w_is_jalr;
    logic             w_call;
    logic             w_return;
    logic [XLEN-1:0]  w_slot_pc;
    logic [XLEN-1:0]  w_link_pc;
    logic [XLEN-1:0]  w_imm_j;
    logic [PTR_W-1:0] w_ptr_m1;
    logic             w_ras_nonempty;
    logic             w_redirect;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_accept;

    assign w_rd           = w_instr[11:7];
    assign w_rs1          = w_instr[19:15];
    assign w_is_jal       = w_found && (w_instr[6:0] == OP_JAL);
    assign w_is_jalr      = w_found && (w_instr[6:0] == OP_JALR);
    assign w_call         = w_found && is_link(w_rd);
    assign w_return       = w_is_jalr && is_link(w_rs1) && !(is_link(w_rd) && (w_rd == w_rs1));
    assign w_slot_pc      = pc_i + (XLEN'(w_slot) << 2);
    assign w_link_pc      = w_slot_pc + XLEN'(4);
    assign w_imm_j        = {{(XLEN-21){w_instr[31]}}, w_instr[31], w_instr[19:12],
                             w_instr[20], w_instr[30:21], 1'b0};
    assign w_ptr_m1       = r_ptr - PTR_W'(1);
    assign w_ras_nonempty = (r_cnt != '0);
    assign w_redirect     = w_is_jal || (w_return && w_ras_nonempty);
    assign w_redirect_pc  = w_is_jal   ? (w_slot_pc + w_imm_j) :
                            w_redirect ? r_ras[w_ptr_m1] : '0;

    assign bundle_rdy_o = !r_vld || pd_rdy_i;
    assign w_accept     = bundle_vld_i && bundle_rdy_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld         <= 1'b0;
            r_pc          <= '0;
            r_instr       <= '0;
            r_slot_vld    <= '0;
            r_jump        <= 1'b0;
            r_jump_slot   <= '0;
            r_call        <= 1'b0;
            r_return      <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (flush_i) begin
            r_vld <= 1'b0;
        end else if (w_accept) begin
            r_vld         <= 1'b1;
            r_pc          <= pc_i;
            r_instr       <= instr_data_i;
            r_slot_vld    <= w_mask;
            r_jump        <= w_found;
            r_jump_slot   <= w_slot;
            r_call        <= w_call;
            r_return      <= w_return;
            r_redirect    <= w_redirect;
            r_redirect_pc <= w_redirect_pc;
        end else if (pd_rdy_i) begin
            r_vld <= 1'b0;
        end
    end

    // r_ptr is the next write slot; the top of stack lives at r_ptr-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (ras_clear_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_call && w_return && w_ras_nonempty) begin
                r_ras[w_ptr_m1] <= w_link_pc;
            end else if (w_call) begin
                r_ras[r_ptr] <= w_link_pc;
                r_ptr        <= r_ptr + PTR_W'(1);
                if (r_cnt != CNT_W'(RAS_DEPTH)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_return && w_ras_nonempty) begin
                r_ptr <= w_ptr_m1;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign pd_vld_o       = r_vld;
    assign pd_pc_o        = r_pc;
    assign pd_instr_o     = r_instr;
    assign pd_slot_vld_o  = r_slot_vld;
    assign pd_jump_o      = r_jump;
    assign pd_jump_slot_o = r_jump_slot;
    assign pd_call_o      = r_call;
    assign pd_return_o    = r_return;
    assign redirect_o     = r_redirect;
    assign redirect_pc_o  = r_redirect_pc;
    assign ras_empty_o    = (r_cnt == '0);

endmodule

// File: tb/tb_pre_decode_ras.sv
// Bench for pre_decode_ras: directed vector table, hand-written RAS/handshake sequences and
// randomized traffic checked against a queue-based model of the pre-decoder.
module tb_pre_decode_ras;

    localparam int FW = 2;
    localparam int XL = 32;
    localparam int D  = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        bundle_vld_i;
    logic        bundle_rdy_o;
    logic [31:0] pc_i;
    logic [63:0] instr_data_i;
    logic [1:0]  instr_vld_i;
    logic        flush_i;
    logic        ras_clear_i;
    logic        pd_vld_o;
    logic        pd_rdy_i;
    logic [31:0] pd_pc_o;
    logic [63:0] pd_instr_o;
    logic [1:0]  pd_slot_vld_o;
    logic        pd_jump_o;
    logic [0:0]  pd_jump_slot_o;
    logic        pd_call_o;
    logic        pd_return_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        ras_empty_o;

    always #5 clk_i = ~clk_i;

    pre_decode_ras #(.FETCH_WIDTH(FW), .XLEN(XL), .RAS_DEPTH(D)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bundle_vld_i  (bundle_vld_i),
        .bundle_rdy_o  (bundle_rdy_o),
        .pc_i          (pc_i),
        .instr_data_i  (instr_data_i),
        .instr_vld_i   (instr_vld_i),
        .flush_i       (flush_i),
        .ras_clear_i   (ras_clear_i),
        .pd_vld_o      (pd_vld_o),
        .pd_rdy_i      (pd_rdy_i),
        .pd_pc_o       (pd_pc_o),
        .pd_instr_o    (pd_instr_o),
        .pd_slot_vld_o (pd_slot_vld_o),
        .pd_jump_o     (pd_jump_o),
        .pd_jump_slot_o(pd_jump_slot_o),
        .pd_call_o     (pd_call_o),
        .pd_return_o   (pd_return_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .ras_empty_o   (ras_empty_o)
    );

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  vld;
        logic        jump;
        logic        slot;
        logic        call;
        logic        ret;
        logic        redir;
        logic [31:0] rpc;
        logic [1:0]  slotvld;
        logic        empty;
    } vec_t;

    vec_t tbl [12];

    // Reference model state
    logic        m_vld;
    logic [31:0] m_pc;
    logic [63:0] m_instr;
    logic [1:0]  m_slotvld;
    logic        m_jump;
    int          m_slot;
    logic        m_call;
    logic        m_ret;
    logic        m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_ras [$];
    logic [31:0] r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int jimm(input logic [31:0] w);
        int v;
        v = int'({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0});
        if (w[31]) v = v - (1 << 21);
        return v;
    endfunction

    function automatic bit link(input logic [4:0] x);
        return (x == 5'd1) || (x == 5'd5);
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_pc = '0; m_instr = '0; m_slotvld = '0; m_jump = 1'b0; m_slot = 0;
        m_call = 1'b0; m_ret = 1'b0; m_redir = 1'b0; m_rpc = '0;
        m_ras.delete();
    endtask

    task automatic model_step();
        bit          acc;
        bit          found;
        int          k;
        logic [31:0] w;
        logic [31:0] lnk;
        bit          is_jalr;
        acc = bundle_vld_i && (!m_vld || pd_rdy_i) && !flush_i;
        found = 1'b0;
        k = 0;
        if (acc) begin
            for (int s = 0; s < FW; s++) begin
                if (!found && instr_vld_i[s] && (instr_data_i[32*s +: 7] == 7'h6F ||
                                                 instr_data_i[32*s +: 7] == 7'h67)) begin
                    found = 1'b1;
                    k = s;
                end
            end
            m_pc = pc_i; m_instr = instr_data_i;
            m_slotvld = found ? (instr_vld_i & 2'((2 << k) - 1)) : instr_vld_i;
            m_jump = found; m_slot = k;
            m_call = 1'b0; m_ret = 1'b0; m_redir = 1'b0; m_rpc = '0;
            if (found) begin
                w = instr_data_i[32*k +: 32];
                is_jalr = (w[6:0] == 7'h67);
                m_call = link(w[11:7]);
                m_ret = is_jalr && link(w[19:15]) && !(link(w[11:7]) && w[11:7] == w[19:15]);
                if (!is_jalr) begin
                    m_redir = 1'b1;
                    m_rpc = pc_i + 32'(4 * k) + 32'(jimm(w));
                end else if (m_ret && m_ras.size() > 0) begin
                    m_redir = 1'b1;
                    m_rpc = m_ras[m_ras.size() - 1];
                end
            end
        end
        if (ras_clear_i) begin
            m_ras.delete();
        end else if (acc && found) begin
            lnk = pc_i + 32'(4 * k + 4);
            if (m_call && m_ret && m_ras.size() > 0) begin
                m_ras[m_ras.size() - 1] = lnk;
            end else if (m_call) begin
                m_ras.push_back(lnk);
                if (m_ras.size() > D) void'(m_ras.pop_front());
            end else if (m_ret && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        if (flush_i) m_vld = 1'b0;
        else if (acc) m_vld = 1'b1;
        else if (pd_rdy_i) m_vld = 1'b0;
    endtask

    task automatic check_model();
        chk("vld", 64'(pd_vld_o), 64'(m_vld));
        chk("pc", 64'(pd_pc_o), 64'(m_pc));
        chk("instr", pd_instr_o, m_instr);
        chk("slot_vld", 64'(pd_slot_vld_o), 64'(m_slotvld));
        chk("jump", 64'(pd_jump_o), 64'(m_jump));
        chk("call", 64'(pd_call_o), 64'(m_call));
        chk("return", 64'(pd_return_o), 64'(m_ret));
        chk("redirect", 64'(redirect_o), 64'(m_redir));
        chk("ras_empty", 64'(ras_empty_o), 64'(m_ras.size() == 0));
        if (m_jump) chk("jump_slot", 64'(pd_jump_slot_o), 64'(m_slot));
        if (m_redir) chk("redirect_pc", 64'(redirect_pc_o), 64'(m_rpc));
    endtask

    // Inputs are already applied; settle, advance one edge, sample 1 time unit later.
    task automatic step(input bit do_check);
        #2;
        if (do_check) chk("bundle_rdy", 64'(bundle_rdy_o), 64'(!m_vld || pd_rdy_i));
        model_step();
        @(posedge clk_i);
        #1;
        if (do_check) check_model();
    endtask

    task automatic idle();
        bundle_vld_i = 1'b0; flush_i = 1'b0; ras_clear_i = 1'b0; pd_rdy_i = 1'b1;
    endtask

    task automatic set_bundle(input logic [31:0] pc, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [1:0] v);
        bundle_vld_i = 1'b1; flush_i = 1'b0; ras_clear_i = 1'b0;
        pc_i = pc; instr_data_i = {i1, i0}; instr_vld_i = v;
    endtask

    task automatic check_vec(input vec_t v, input int i);
        chk($sformatf("t%0d.vld", i), 64'(pd_vld_o), 64'(1'b1));
        chk($sformatf("t%0d.pc", i), 64'(pd_pc_o), 64'(v.pc));
        chk($sformatf("t%0d.slot_vld", i), 64'(pd_slot_vld_o), 64'(v.slotvld));
        chk($sformatf("t%0d.jump", i), 64'(pd_jump_o), 64'(v.jump));
        chk($sformatf("t%0d.call", i), 64'(pd_call_o), 64'(v.call));
        chk($sformatf("t%0d.return", i), 64'(pd_return_o), 64'(v.ret));
        chk($sformatf("t%0d.redirect", i), 64'(redirect_o), 64'(v.redir));
        chk($sformatf("t%0d.ras_empty", i), 64'(ras_empty_o), 64'(v.empty));
        if (v.jump) chk($sformatf("t%0d.jump_slot", i), 64'(pd_jump_slot_o), 64'(v.slot));
        if (v.redir) chk($sformatf("t%0d.redirect_pc", i), 64'(redirect_pc_o), 64'(v.rpc));
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'd6;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0013;
            1, 2: return {x[31:12], pick_reg(), 7'h6F};
            3, 4: return {x[31:20], pick_reg(), 3'b000, pick_reg(), 7'h67};
            default: return x;
        endcase
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        tbl[0]  = '{32'h1000, 32'h13, 32'h100000EF, 2'b11,
                    1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1104, 2'b11, 1'b0};
        tbl[1]  = '{32'h1104, 32'h8067, 32'h13, 2'b11,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1008, 2'b01, 1'b1};
        tbl[2]  = '{32'h1104, 32'h8067, 32'h13, 2'b11,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1};
        tbl[3]  = '{32'h3000, 32'h13, 32'h13, 2'b11,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b11, 1'b1};
        tbl[4]  = '{32'h3000, 32'h100000EF, 32'h13, 2'b10,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 1'b1};
        tbl[5]  = '{32'h4000, 32'h13, 32'hFFDFF06F, 2'b11,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000, 2'b11, 1'b1};
        tbl[6]  = '{32'h5000, 32'h00030067, 32'h100000EF, 2'b11,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 1'b1};
        tbl[7]  = '{32'h2000, 32'h100002EF, 32'h13, 2'b01,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2100, 2'b01, 1'b0};
        tbl[8]  = '{32'h6000, 32'h13, 32'h000280E7, 2'b11,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2004, 2'b11, 1'b0};
        tbl[9]  = '{32'h7000, 32'h8067, 32'h13, 2'b01,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h6008, 2'b01, 1'b1};
        tbl[10] = '{32'h8000, 32'h000080E7, 32'h13, 2'b01,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b0};
        tbl[11] = '{32'h9000, 32'h8067, 32'h13, 2'b01,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8004, 2'b01, 1'b1};

        idle();
        pc_i = '0; instr_data_i = '0; instr_vld_i = '0;
        rst_ni = 1'b0;
        model_reset();
        #12;
        chk("rst.vld", 64'(pd_vld_o), 64'(1'b0));
        chk("rst.pc", 64'(pd_pc_o), 64'(32'h0));
        chk("rst.redirect", 64'(redirect_o), 64'(1'b0));
        chk("rst.ras_empty", 64'(ras_empty_o), 64'(1'b1));
        chk("rst.bundle_rdy", 64'(bundle_rdy_o), 64'(1'b1));
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 12; i++) begin
            set_bundle(tbl[i].pc, tbl[i].i0, tbl[i].i1, tbl[i].vld);
            pd_rdy_i = 1'b1;
            step(1'b0);
            check_vec(tbl[i], i);
        end

        // Overflow: D+1 calls, then D+1 returns
        idle(); ras_clear_i = 1'b1; step(1'b0);
        for (int i = 0; i <= D; i++) begin
            set_bundle(32'(i * 256), 32'h100000EF, 32'h13, 2'b01);
            step(1'b0);
        end
        chk("ovf.ras_empty", 64'(ras_empty_o), 64'(1'b0));
        for (int i = 0; i <= D; i++) begin
            set_bundle(32'hA000, 32'h8067, 32'h13, 2'b01);
            step(1'b0);
            chk($sformatf("ovf.ret%0d.redirect", i), 64'(redirect_o), 64'(i < D));
            if (i < D) chk($sformatf("ovf.ret%0d.pc", i), 64'(redirect_pc_o),
                           64'(32'h4 + 32'((D - i) * 256)));
        end
        chk("ovf.ras_empty_end", 64'(ras_empty_o), 64'(1'b1));

        // Backpressure then flush
        set_bundle(32'h100, 32'h100000EF, 32'h13, 2'b01);
        step(1'b0);
        for (int i = 0; i < 3; i++) begin
            set_bundle(32'h900, 32'h100000EF, 32'h13, 2'b01);
            pd_rdy_i = 1'b0;
            #2;
            chk("hold.bundle_rdy", 64'(bundle_rdy_o), 64'(1'b0));
            step(1'b0);
            chk("hold.vld", 64'(pd_vld_o), 64'(1'b1));
            chk("hold.pc", 64'(pd_pc_o), 64'(32'h100));
            chk("hold.ras_empty", 64'(ras_empty_o), 64'(1'b0));
        end
        flush_i = 1'b1;
        step(1'b0);
        chk("flush.vld", 64'(pd_vld_o), 64'(1'b0));
        chk("flush.pc", 64'(pd_pc_o), 64'(32'h100));
        set_bundle(32'hB000, 32'h8067, 32'h13, 2'b01);
        pd_rdy_i = 1'b1;
        step(1'b0);
        chk("flush.ret.redirect", 64'(redirect_o), 64'(1'b1));
        chk("flush.ret.pc", 64'(redirect_pc_o), 64'(32'h104));
        chk("flush.ret.ras_empty", 64'(ras_empty_o), 64'(1'b1));

        // Clear wins over a same-cycle push
        set_bundle(32'h300, 32'h100000EF, 32'h13, 2'b01);
        ras_clear_i = 1'b1;
        step(1'b0);
        chk("clr.call", 64'(pd_call_o), 64'(1'b1));
        chk("clr.ras_empty", 64'(ras_empty_o), 64'(1'b1));

        // Asynchronous reset mid-stream
        set_bundle(32'hC000, 32'h100000EF, 32'h13, 2'b01);
        step(1'b0);
        chk("arst.pre_vld", 64'(pd_vld_o), 64'(1'b1));
        rst_ni = 1'b0;
        #2;
        chk("arst.vld", 64'(pd_vld_o), 64'(1'b0));
        chk("arst.pc", 64'(pd_pc_o), 64'(32'h0));
        chk("arst.call", 64'(pd_call_o), 64'(1'b0));
        chk("arst.redirect", 64'(redirect_o), 64'(1'b0));
        chk("arst.ras_empty", 64'(ras_empty_o), 64'(1'b1));
        model_reset();
        idle();
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int n = 0; n < 400; n++) begin
            bundle_vld_i = ($urandom_range(0, 3) != 0);
            pd_rdy_i     = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 15) == 0);
            ras_clear_i  = ($urandom_range(0, 31) == 0);
            r = $urandom();
            pc_i = {r[31:2], 2'b00};
            instr_data_i = {rand_instr(), rand_instr()};
            instr_vld_i  = 2'($urandom_range(0, 3));
            step(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pre_decode_ras.md
Name: pre_decode_ras

Overview:
- Next-generation fetch pre-decoder. Scans a FETCH_WIDTH-instruction fetch bundle and locates the first valid unconditional jump (JAL or JALR).
- Classifies that jump as a call, return or plain jump, computes the JAL target, and maintains a speculative return-address stack (RAS) to predict return targets.
- Sits between the instruction-memory response and the fetch queue. It is a one-entry registered pipeline stage with a valid/ready handshake, and it drives the fetch-redirect path.

Parameters:
- FETCH_WIDTH, 2: instructions per bundle, 1..8. Instructions are 32-bit; slot k sits at pc_i + 4*k.
- XLEN, 32: PC and address width.
- RAS_DEPTH, 8: RAS entries, power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- bundle_vld_i  in  1  input bundle valid
- bundle_rdy_o  out  1  stage can accept a bundle
- pc_i  in  XLEN  PC of slot 0
- instr_data_i  in  32*FETCH_WIDTH  instructions; slot k occupies [32k+31:32k]
- instr_vld_i  in  FETCH_WIDTH  per-slot valid
- flush_i  in  1  backend flush
- ras_clear_i  in  1  empty the RAS
- pd_vld_o  out  1  output bundle valid
- pd_rdy_i  in  1  downstream ready
- pd_pc_o  out  XLEN  registered pc_i
- pd_instr_o  out  32*FETCH_WIDTH  registered instructions
- pd_slot_vld_o  out  FETCH_WIDTH  valid slots, truncated after the first jump
- pd_jump_o  out  1  bundle contains a jump
- pd_jump_slot_o  out  $clog2(FETCH_WIDTH) (min 1)  slot index of that jump
- pd_call_o  out  1  the jump is a call
- pd_return_o  out  1  the jump is a return
- redirect_o  out  1  predicted target valid, fetch must redirect
- redirect_pc_o  out  XLEN  predicted target
- ras_empty_o  out  1  RAS count is 0 (live, unregistered)

Behaviour:
- Reset: every output register is 0, pd_vld_o=0, RAS pointer and count are 0, ras_empty_o=1.
- Handshake:
  - bundle_rdy_o = !pd_vld_o || pd_rdy_i.
  - Accept occurs when bundle_vld_i && bundle_rdy_o && !flush_i. Outputs appear on the next cycle, so latency is 1.
  - If an accept and a downstream drain happen in the same cycle, the register is replaced.
  - pd_vld_o drops to 0 only on a drain without an accept, or on flush.
- flush_i: clears pd_vld_o, blocks accept that cycle, and leaves the RAS unchanged.
- ras_clear_i: pointer and count go to 0. It has priority over any push or pop in the same cycle.
- Decode, per valid slot, combinational on the input:
  - jal = opcode 1101111; jalr = opcode 1100111.
  - link(r) = (r==x1 || r==x5).
- First jump: the lowest k with instr_vld_i[k] && (jal||jalr).
  - pd_slot_vld_o = instr_vld_i masked to bits 0..k.
  - If no jump exists: pd_jump_o=0, the mask equals instr_vld_i, and there is no RAS action.
- Classification of the first jump:
  - call = link(rd).
  - return = jalr && link(rs1) && !(link(rd) && rd==rs1).
  - Stack actions:
    - return only: pop.
    - call only: push.
    - both (e.g. rd=x1, rs1=x5): pop then push, i.e. the top entry is replaced.
- Push value: pc_i + 4k + 4, modulo 2^XLEN.
- Targets:
  - JAL: pc_i + 4k + sext(imm_j), modulo 2^XLEN, with redirect_o=1.
  - Return: redirect_pc_o = RAS top before the pop, with redirect_o=1 only if count>0.
  - Non-return JALR: redirect_o=0 (resolved in the backend).
  - JALR call: target not predicted.
- RAS update:
  - The RAS updates only in the accept cycle, speculatively.
  - Circular buffer. Push when full overwrites the oldest entry and count stays at RAS_DEPTH.
  - Pop when empty: count stays 0, pointer is unchanged, no redirect.
  - Pointer wraps modulo RAS_DEPTH.
- Slots after the first jump are never decoded, so they cause no RAS action.
- Reset asserted mid-operation: immediate return to the reset state. Any in-flight bundle is lost.

Test Plan:
- Reset, then bundle pc=0x1000, slot0=0x00000013 (nop), slot1=0x100000EF (jal x1,+0x100), both valid.
  - Next cycle: pd_vld_o=1, jump_slot=1, call=1, redirect_pc=0x1104, ras_empty_o=0.
- Next bundle pc=0x1104, slot0=0x00008067 (ret).
  - return=1, redirect_o=1, redirect_pc=0x1008, slot_vld=01, ras_empty_o=1.
- ret with the RAS empty -> return=1, redirect_o=0, RAS count stays 0, no pointer change.
- RAS_DEPTH+1 calls from pc=0x0,0x100,..., then RAS_DEPTH+1 rets.
  - The first RAS_DEPTH rets predict in reverse order, ending at pc 0x104.
  - The last ret has redirect_o=0.
- Hold pd_rdy_i=0 with the output valid -> bundle_rdy_o=0, outputs stable, RAS unchanged.
  - Then assert flush_i with bundle_vld_i=1 -> pd_vld_o=0 next cycle, no accept, RAS unchanged.
- jalr x1,0(x5) after one push of 0x2004 -> pop+push: redirect_pc=0x2004, new top = pc+4k+4, count stays 1.
  - Assert rst_ni low mid-stream -> all outputs 0 asynchronously.
